// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store control unit in front of a word-addressed data
// memory with per-byte write enables and a one-cycle registered read.
//
// Accepts one request at a time. In ACCESS it either writes, starts a read,
// or reports a fault. Loads finish in LOAD_DATA, where the returned lane is
// aligned and extended into a registered response.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   in_req_*             request (valid/ready handshake, store flag,
//                        funct3, byte address, right-justified store data)
//   out_rsp_*            one-cycle registered response pulse, data, fault
//   out_mem_*            word address, rw_mode (1 = read), write data,
//                        byte enables
//   in_mem_data          memory read data (valid the cycle after the address)
//
// Optional feature macro: LSU_BOUNDS_CHECK_EN -- when defined, byte addresses
// above the memory range fault instead of aliasing.
module lsu_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              in_req_valid,
  output logic              out_req_ready,
  input  logic              in_req_is_store,
  input  logic [2:0]        in_req_funct3,
  input  logic [31:0]       in_req_addr,
  input  logic [31:0]       in_req_wdata,
  output logic              out_rsp_valid,
  output logic [31:0]       out_rsp_rdata,
  output logic              out_rsp_fault,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_rw_mode,
  output logic [31:0]       out_mem_write_data,
  output logic [3:0]        out_mem_byte_en,
  input  logic [31:0]       in_mem_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_LOAD_DATA
  } state_t;

  state_t            state_q, state_d;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              oob_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic              accept;
  logic              oob_in;
  logic              fault;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  assign out_req_ready = (state_q == ST_IDLE);
  assign accept        = in_req_valid && out_req_ready;

  // Out-of-range detection is resolved at accept time so only one flag bit
  // has to be carried instead of the full upper address.
`ifdef LSU_BOUNDS_CHECK_EN
  assign oob_in = |in_req_addr[31:ADDR_W+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^in_req_addr[31:ADDR_W+2];
  assign oob_in         = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      oob_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      if (accept) begin
        is_store_q <= in_req_is_store;
        funct3_q   <= in_req_funct3;
        addr_q     <= in_req_addr[ADDR_W+1:0];
        wdata_q    <= in_req_wdata;
        oob_q      <= oob_in;
      end
    end
  end

  // Misalignment / illegal width classification of the latched request.
  always_comb begin
    fault = oob_q;
    case (funct3_q)
      3'b000:  ;
      3'b001:  if (addr_q[0]) fault = 1'b1;
      3'b010:  if (addr_q[1:0] != 2'b00) fault = 1'b1;
      3'b100:  if (is_store_q) fault = 1'b1;
      3'b101:  if (is_store_q || addr_q[0]) fault = 1'b1;
      default: fault = 1'b1;
    endcase
  end

  // Lane select and extension of the returned memory word.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = in_mem_data[7:0];
      2'b01:   byte_sel = in_mem_data[15:8];
      2'b10:   byte_sel = in_mem_data[23:16];
      default: byte_sel = in_mem_data[31:24];
    endcase
    half_sel = addr_q[1] ? in_mem_data[31:16] : in_mem_data[15:0];
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
      2'b01:   load_data = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
      default: load_data = in_mem_data;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    rsp_valid_d        = 1'b0;
    rsp_rdata_d        = '0;
    rsp_fault_d        = 1'b0;
    out_mem_addr       = '0;
    out_mem_rw_mode    = 1'b1;
    out_mem_write_data = '0;
    out_mem_byte_en    = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        out_mem_addr = addr_q[ADDR_W+1:2];
        if (fault) begin
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (is_store_q) begin
          out_mem_rw_mode = 1'b0;
          case (funct3_q[1:0])
            2'b00: begin
              out_mem_byte_en    = 4'b0001 << addr_q[1:0];
              out_mem_write_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
              out_mem_byte_en    = addr_q[1] ? 4'b1100 : 4'b0011;
              out_mem_write_data = {2{wdata_q[15:0]}};
            end
            default: begin
              out_mem_byte_en    = 4'b1111;
              out_mem_write_data = wdata_q;
            end
          endcase
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_LOAD_DATA;
        end
      end
      ST_LOAD_DATA: begin
        out_mem_addr = addr_q[ADDR_W+1:2];
        rsp_valid_d  = 1'b1;
        rsp_rdata_d  = load_data;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A store caught by reset in ACCESS must not reach memory.
    if (i_rst) begin
      out_mem_rw_mode    = 1'b1;
      out_mem_write_data = '0;
      out_mem_byte_en    = 4'b0000;
    end
  end

  assign out_rsp_valid = rsp_valid_q;
  assign out_rsp_rdata = rsp_rdata_q;
  assign out_rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int ADDR_W = 10;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              in_req_valid = 1'b0;
  logic              out_req_ready;
  logic              in_req_is_store = 1'b0;
  logic [2:0]        in_req_funct3 = 3'b000;
  logic [31:0]       in_req_addr = '0;
  logic [31:0]       in_req_wdata = '0;
  logic              out_rsp_valid;
  logic [31:0]       out_rsp_rdata;
  logic              out_rsp_fault;
  logic [ADDR_W-1:0] out_mem_addr;
  logic              out_mem_rw_mode;
  logic [31:0]       out_mem_write_data;
  logic [3:0]        out_mem_byte_en;
  logic [31:0]       in_mem_data;

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .in_req_valid       (in_req_valid),
    .out_req_ready      (out_req_ready),
    .in_req_is_store    (in_req_is_store),
    .in_req_funct3      (in_req_funct3),
    .in_req_addr        (in_req_addr),
    .in_req_wdata       (in_req_wdata),
    .out_rsp_valid      (out_rsp_valid),
    .out_rsp_rdata      (out_rsp_rdata),
    .out_rsp_fault      (out_rsp_fault),
    .out_mem_addr       (out_mem_addr),
    .out_mem_rw_mode    (out_mem_rw_mode),
    .out_mem_write_data (out_mem_write_data),
    .out_mem_byte_en    (out_mem_byte_en),
    .in_mem_data        (in_mem_data)
  );

  always #5 i_clk = ~i_clk;

  // Data memory: byte-enabled write, registered read.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge i_clk) begin
    if (!out_mem_rw_mode) begin
      for (int b = 0; b < 4; b++)
        if (out_mem_byte_en[b]) mem[out_mem_addr][b*8 +: 8] <= out_mem_write_data[b*8 +: 8];
    end
    in_mem_data <= mem[out_mem_addr];
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
    string       tag;
  } rsp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       data;
    int                due;
    string             tag;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  // Response monitor
  always @(negedge i_clk) begin
    if (out_rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", {31'b0, out_rsp_valid}, 32'd0);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk({e.tag, "_rdata"}, out_rsp_rdata, e.rdata);
        chk({e.tag, "_fault"}, {31'b0, out_rsp_fault}, {31'b0, e.fault});
        chk({e.tag, "_cycle"}, cyc, e.due);
        $display("rsp %s rdata=0x%08h fault=%0b cycle=%0d", e.tag, out_rsp_rdata, out_rsp_fault, cyc);
      end
    end
  end

  // Memory write monitor
  always @(negedge i_clk) begin
    if (out_mem_rw_mode !== 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {31'b0, out_mem_rw_mode}, 32'd1);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk({w.tag, "_waddr"}, {22'b0, out_mem_addr}, {22'b0, w.addr});
        chk({w.tag, "_be"}, {28'b0, out_mem_byte_en}, {28'b0, w.be});
        chk({w.tag, "_wdata"}, out_mem_write_data, w.data);
        chk({w.tag, "_wcycle"}, cyc, w.due);
        $display("wr  %s addr=%0d be=%04b data=0x%08h", w.tag, out_mem_addr, out_mem_byte_en, out_mem_write_data);
      end
    end
  end

  // Issue one request; push expected response/write on the accept edge.
  task automatic req(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input bit exp_rsp, input logic exp_fault, input logic [31:0] exp_rd,
                     input bit exp_wr, input logic [ADDR_W-1:0] wa,
                     input logic [3:0] wbe, input logic [31:0] wdat);
    int n;
    int acc;
    @(negedge i_clk);
    in_req_valid    = 1'b1;
    in_req_is_store = st;
    in_req_funct3   = f3;
    in_req_addr     = a;
    in_req_wdata    = wd;
    n = 0;
    while (!out_req_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!out_req_ready) begin
      chk({tag, "_ready_timeout"}, {31'b0, out_req_ready}, 32'd1);
      in_req_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge i_clk);
    if (exp_rsp) begin
      rsp_t r;
      r.rdata = exp_rd;
      r.fault = exp_fault;
      r.due   = acc + ((st || exp_fault) ? 2 : 3);
      r.tag   = tag;
      rsp_q.push_back(r);
    end
    if (exp_wr) begin
      wr_t w;
      w.addr = wa;
      w.be   = wbe;
      w.data = wdat;
      w.due  = acc + 1;
      w.tag  = tag;
      wr_q.push_back(w);
    end
    #1;
    in_req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_rsp_valid", {31'b0, out_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", out_rsp_rdata, 32'd0);
    chk("rst_rsp_fault", {31'b0, out_rsp_fault}, 32'd0);
    chk("rst_ready", {31'b0, out_req_ready}, 32'd1);
    chk("rst_rw_mode", {31'b0, out_mem_rw_mode}, 32'd1);
    chk("rst_byte_en", {28'b0, out_mem_byte_en}, 32'd0);
    chk("rst_wdata", out_mem_write_data, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("idle_mem_addr", {22'b0, out_mem_addr}, 32'd0);

    //  tag       st    f3      addr        wdata         rsp fault rdata          wr  waddr be       wdata
    req("sw0",    1'b1, 3'b010, 32'h000, 32'h12345678, 1, 1'b0, 32'h0,          1, 10'd0, 4'b1111, 32'h12345678);
    req("sw10",   1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1, 1'b0, 32'h0,          1, 10'd4, 4'b1111, 32'hDEADBEEF);
    req("lw10",   1'b0, 3'b010, 32'h010, 32'h0,        1, 1'b0, 32'hDEADBEEF,   0, 10'd0, 4'b0000, 32'h0);
    req("sb13",   1'b1, 3'b000, 32'h013, 32'h000000A5, 1, 1'b0, 32'h0,          1, 10'd4, 4'b1000, 32'hA5A5A5A5);
    req("lb13",   1'b0, 3'b000, 32'h013, 32'h0,        1, 1'b0, 32'hFFFFFFA5,   0, 10'd0, 4'b0000, 32'h0);
    req("lbu13",  1'b0, 3'b100, 32'h013, 32'h0,        1, 1'b0, 32'h000000A5,   0, 10'd0, 4'b0000, 32'h0);
    req("sh06",   1'b1, 3'b001, 32'h006, 32'h00008001, 1, 1'b0, 32'h0,          1, 10'd1, 4'b1100, 32'h80018001);
    req("lh06",   1'b0, 3'b001, 32'h006, 32'h0,        1, 1'b0, 32'hFFFF8001,   0, 10'd0, 4'b0000, 32'h0);
    req("lhu06",  1'b0, 3'b101, 32'h006, 32'h0,        1, 1'b0, 32'h00008001,   0, 10'd0, 4'b0000, 32'h0);
    req("lb10",   1'b0, 3'b000, 32'h010, 32'h0,        1, 1'b0, 32'hFFFFFFEF,   0, 10'd0, 4'b0000, 32'h0);
    req("lh12",   1'b0, 3'b001, 32'h012, 32'h0,        1, 1'b0, 32'hFFFFA5AD,   0, 10'd0, 4'b0000, 32'h0);
    req("lbu11",  1'b0, 3'b100, 32'h011, 32'h0,        1, 1'b0, 32'h000000BE,   0, 10'd0, 4'b0000, 32'h0);
    // Faults: no write, single pulse with fault=1
    req("lw02",   1'b0, 3'b010, 32'h002, 32'h0,        1, 1'b1, 32'h0,          0, 10'd0, 4'b0000, 32'h0);
    req("sh01",   1'b1, 3'b001, 32'h001, 32'hFFFF,     1, 1'b1, 32'h0,          0, 10'd0, 4'b0000, 32'h0);
    req("ld011",  1'b0, 3'b011, 32'h010, 32'h0,        1, 1'b1, 32'h0,          0, 10'd0, 4'b0000, 32'h0);
    req("sbu",    1'b1, 3'b100, 32'h000, 32'h77,       1, 1'b1, 32'h0,          0, 10'd0, 4'b0000, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
    req("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0,       1, 1'b1, 32'h0,          0, 10'd0, 4'b0000, 32'h0);
`else
    req("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0,       1, 1'b0, 32'h12345678,   0, 10'd0, 4'b0000, 32'h0);
`endif

    // Reset while a store sits in ACCESS: no write, no response.
    req("sw_rst", 1'b1, 3'b010, 32'h010, 32'h11111111, 0, 1'b0, 32'h0,          0, 10'd0, 4'b0000, 32'h0);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rstacc_rw_mode", {31'b0, out_mem_rw_mode}, 32'd1);
    chk("rstacc_byte_en", {28'b0, out_mem_byte_en}, 32'd0);
    chk("rstacc_wdata", out_mem_write_data, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rstacc_rsp_valid", {31'b0, out_rsp_valid}, 32'd0);
    chk("rstacc_rsp_rdata", out_rsp_rdata, 32'd0);
    chk("rstacc_ready", {31'b0, out_req_ready}, 32'd1);
    req("lw_after_rst", 1'b0, 3'b010, 32'h010, 32'h0,  1, 1'b0, 32'hA5ADBEEF,   0, 10'd0, 4'b0000, 32'h0);

    repeat (6) @(negedge i_clk);
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
